// File: rtl/trace_pkg.sv
// Shared constants for the trace capture path: opcodes, FSM encoding, widths.
package trace_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 9;
  localparam int CNT_W  = 7;

  localparam logic [7:0] OP_CAPTURE = 8'h0A;
  localparam logic [7:0] OP_ABORT   = 8'h0B;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_TRIG    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // A count field of zero means the full 128-word capture.
  function automatic logic [7:0] words_from_field(input logic [CNT_W-1:0] field);
    return (field == '0) ? 8'd128 : {1'b0, field};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; pointers carry an extra wrap bit.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_capture.sv
// Trace receiver: selects a mux channel, deserialises q into 16-bit words, buffers them for the host.
// Optional TRACE_CAPTURE_TRIGGER_EN adds a TRIG state that waits for the first 0->1 edge on q.
//
// state   | meaning
// IDLE    | waiting for OP_CAPTURE
// ARM     | select driven, waiting for the mux echo (bounded by ARM_TIMEOUT)
// TRIG    | waiting for first rising edge on q (trigger build only)
// CAPTURE | shifting q into words, pushing each completed word
// DRAIN   | all words captured, waiting for the FIFO to empty
module trace_capture
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              req_stb,
  input  logic [7:0]        bRequest,
  input  logic [15:0]       parameter_Block16,
  output logic [SEL_W-1:0]  select,
  input  logic [SEL_W-1:0]  actual_select,
  input  logic              q,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              overflow,
  output logic              arm_fail
);

  localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

`ifdef TRACE_CAPTURE_TRIGGER_EN
  localparam logic [2:0] ST_AFTER_ARM = ST_TRIG;
`else
  localparam logic [2:0] ST_AFTER_ARM = ST_CAPTURE;
`endif

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [7:0]        words_left_q, words_left_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic              overflow_q, overflow_d;
  logic              arm_fail_q, arm_fail_d;
`ifdef TRACE_CAPTURE_TRIGGER_EN
  logic              q_prev_q;
`endif

  logic              push, pop, flush;
  logic [WORD_W-1:0] push_word;
  logic              fifo_empty, fifo_full;
  logic [WORD_W-1:0] fifo_rdata;
  logic              start, abort, sel_match;

  assign start     = req_stb && (bRequest == OP_CAPTURE);
  assign abort     = req_stb && (bRequest == OP_ABORT);
  assign sel_match = (actual_select == select_q);
  // Shift right so the first captured bit ends up in [0].
  assign push_word = {q, shift_q[WORD_W-1:1]};
  assign pop       = word_valid && word_ready;

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    words_left_d = words_left_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    arm_cnt_d    = arm_cnt_q;
    overflow_d   = overflow_q;
    arm_fail_d   = arm_fail_q;
    push         = 1'b0;
    flush        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ARM;
          select_d     = parameter_Block16[SEL_W-1:0];
          words_left_d = words_from_field(parameter_Block16[15:SEL_W]);
          arm_cnt_d    = '0;
          bit_cnt_d    = '0;
          overflow_d   = 1'b0;
          arm_fail_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (sel_match) begin
          state_d   = ST_AFTER_ARM;
          bit_cnt_d = '0;
        end else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          arm_fail_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
`ifdef TRACE_CAPTURE_TRIGGER_EN
      ST_TRIG: begin
        if (!sel_match) begin
          state_d = ST_IDLE;
        end else if (q && !q_prev_q) begin
          state_d   = ST_CAPTURE;
          shift_d   = push_word;
          bit_cnt_d = 4'd1;
        end
      end
`endif
      ST_CAPTURE: begin
        if (!sel_match) begin
          state_d = ST_IDLE;
        end else begin
          shift_d   = push_word;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            push         = 1'b1;
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) state_d = ST_DRAIN;
            // Lost words still count toward the request.
            if (fifo_full && !pop) overflow_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
      push    = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= ST_IDLE;
      select_q     <= '0;
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      arm_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      arm_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      words_left_q <= words_left_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      arm_cnt_q    <= arm_cnt_d;
      overflow_q   <= overflow_d;
      arm_fail_q   <= arm_fail_d;
    end
  end

`ifdef TRACE_CAPTURE_TRIGGER_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) q_prev_q <= 1'b0;
    else         q_prev_q <= q;
  end
`endif

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (rclk),
    .rst_n_i (rrst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign select     = select_q;
  assign word_valid = !fifo_empty;
  assign word_data  = fifo_empty ? '0 : fifo_rdata;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;
  assign arm_fail   = arm_fail_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (default build or TRACE_CAPTURE_TRIGGER_EN).
module tb_trace_capture;
  import trace_pkg::*;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        req_stb = 1'b0;
  logic [7:0]  bRequest = 8'h00;
  logic [15:0] pb16 = 16'h0000;
  logic [8:0]  select;
  logic [8:0]  actual_select = 9'd0;
  logic        q = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        busy;
  logic        overflow;
  logic        arm_fail;

  int checks = 0;
  int errors = 0;
  logic [15:0] got_q[$];

  trace_capture #(.FIFO_DEPTH(8), .ARM_TIMEOUT(15)) dut (
    .rclk              (rclk),
    .rrst_n            (rrst_n),
    .req_stb           (req_stb),
    .bRequest          (bRequest),
    .parameter_Block16 (pb16),
    .select            (select),
    .actual_select     (actual_select),
    .q                 (q),
    .word_data         (word_data),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .busy              (busy),
    .overflow          (overflow),
    .arm_fail          (arm_fail)
  );

  always #5 rclk = ~rclk;

  // Records every word the consumer accepts at the next rising edge.
  always @(negedge rclk) begin
    if (rrst_n && word_valid && word_ready) got_q.push_back(word_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge rclk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      q = w[i];
      step();
    end
  endtask

  // Strobe, then echo the channel so the ARM state sees the match on the third edge after the strobe.
  task automatic start_capture(input logic [6:0] cnt, input logic [8:0] ch);
    actual_select = 9'd0;
    req_stb = 1'b1;
    bRequest = OP_CAPTURE;
    pb16 = {cnt, ch};
    step();
    req_stb = 1'b0;
    step();
    step();
    actual_select = ch;
    step();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy got %b want 0 after %0d cycles", tag, busy, budget);
    end
  endtask

  task automatic check_words(input int n, input logic [15:0] base, input string tag);
    int bad = 0;
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words want %0d", tag, got_q.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        if (got_q[k] !== 16'(base + 16'(k))) begin
          bad++;
          if (bad == 1) $display("FAIL %s_data: word %0d got %h want %h", tag, k, got_q[k], 16'(base + 16'(k)));
        end
      end
      if (bad != 0) errors++;
    end
  endtask

  task automatic test_reset;
    rrst_n = 1'b0;
    #3;
    checks++;
    if ({select, word_data, word_valid, busy, overflow, arm_fail} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {select, word_data, word_valid, busy, overflow, arm_fail});
    end
    step();
    step();
    rrst_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    got_q.delete();
    word_ready = 1'b1;
    start_capture(7'd2, 9'd37);
    checks++;
    if (select !== 9'd37 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_arm: select %0d busy %b want 37 1", select, busy);
    end
    drive_word(16'hA5C3);
    drive_word(16'h0FF0);
    q = 1'b0;
    wait_idle(20, "basic_drain");
    step();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count: got %0d words want 2", got_q.size());
    end else if (got_q[0] !== 16'hA5C3 || got_q[1] !== 16'h0FF0) begin
      errors++;
      $display("FAIL basic_data: got %h %h want a5c3 0ff0", got_q[0], got_q[1]);
    end
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid: got %b want 0", word_valid);
    end
  endtask

  task automatic test_arm_timeout;
    actual_select = 9'd0;
    req_stb = 1'b1;
    bRequest = OP_CAPTURE;
    pb16 = {7'd1, 9'd200};
    step();
    pb16 = {7'd3, 9'd300};
    step();
    req_stb = 1'b0;
    checks++;
    if (select !== 9'd200) begin
      errors++;
      $display("FAIL capture_while_busy: select got %0d want 200", select);
    end
    repeat (13) step();
    checks++;
    if (busy !== 1'b1 || arm_fail !== 1'b0) begin
      errors++;
      $display("FAIL arm_before_timeout: busy %b arm_fail %b want 1 0", busy, arm_fail);
    end
    step();
    checks++;
    if (busy !== 1'b0 || arm_fail !== 1'b1 || select !== 9'd200) begin
      errors++;
      $display("FAIL arm_timeout: busy %b arm_fail %b select %0d want 0 1 200", busy, arm_fail, select);
    end
  endtask

  task automatic test_ignore_opcode;
    req_stb = 1'b1;
    bRequest = 8'h55;
    pb16 = {7'd1, 9'd11};
    step();
    req_stb = 1'b0;
    checks++;
    if (busy !== 1'b0 || arm_fail !== 1'b1) begin
      errors++;
      $display("FAIL ignore_opcode: busy %b arm_fail %b want 0 1", busy, arm_fail);
    end
  endtask

  task automatic test_overflow;
    word_ready = 1'b0;
    got_q.delete();
    start_capture(7'd10, 9'd5);
    checks++;
    if (arm_fail !== 1'b0) begin
      errors++;
      $display("FAIL arm_fail_clear: got %b want 0", arm_fail);
    end
    for (int k = 0; k < 10; k++) drive_word(16'(16'h1100 + 16'(k)));
    step();
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1 || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: overflow %b busy %b valid %b want 1 1 1", overflow, busy, word_valid);
    end
    word_ready = 1'b1;
    wait_idle(30, "overflow_drain");
    step();
    check_words(8, 16'h1100, "overflow");
  endtask

  task automatic test_full_push_pop;
    logic [15:0] w;
    word_ready = 1'b0;
    got_q.delete();
    start_capture(7'd9, 9'd6);
    for (int k = 0; k < 8; k++) drive_word(16'(16'h2200 + 16'(k)));
    w = 16'h2208;
    for (int i = 0; i < 15; i++) begin
      q = w[i];
      step();
    end
    word_ready = 1'b1;
    q = w[15];
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_overflow: got %b want 0", overflow);
    end
    wait_idle(30, "full_push_pop_drain");
    step();
    check_words(9, 16'h2200, "full_push_pop");
  endtask

  task automatic test_abort;
    logic [15:0] w;
    word_ready = 1'b1;
    got_q.delete();
    start_capture(7'd4, 9'd7);
    drive_word(16'h3300);
    drive_word(16'h3301);
    w = 16'h3302;
    for (int i = 0; i < 5; i++) begin
      q = w[i];
      step();
    end
    req_stb = 1'b1;
    bRequest = OP_ABORT;
    q = w[5];
    step();
    req_stb = 1'b0;
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy %b valid %b want 0 0", busy, word_valid);
    end
    repeat (20) step();
    check_words(2, 16'h3300, "abort");
  endtask

  task automatic test_count_zero;
    word_ready = 1'b1;
    got_q.delete();
    start_capture(7'd0, 9'd8);
    for (int k = 0; k < 128; k++) drive_word(16'(16'h8000 + 16'(k)));
    wait_idle(20, "count_zero_drain");
    step();
    check_words(128, 16'h8000, "count_zero");
  endtask

  task automatic test_reset_mid_capture;
    word_ready = 1'b0;
    got_q.delete();
    start_capture(7'd3, 9'd9);
    drive_word(16'h4444);
    for (int i = 0; i < 10; i++) begin
      q = i[0];
      step();
    end
    checks++;
    if (word_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: valid %b busy %b want 1 1", word_valid, busy);
    end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({select, word_data, word_valid, busy, overflow, arm_fail} !== 29'd0) begin
      errors++;
      $display("FAIL reset_mid_capture: got %h want 0", {select, word_data, word_valid, busy, overflow, arm_fail});
    end
    step();
    rrst_n = 1'b1;
    word_ready = 1'b1;
    actual_select = 9'd0;
    repeat (20) step();
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_word: words %0d busy %b want 0 0", got_q.size(), busy);
    end
  endtask

  task automatic test_trigger;
    logic [15:0] exp;
`ifdef TRACE_CAPTURE_TRIGGER_EN
    exp = 16'h5555;
`else
    exp = 16'h0000;
`endif
    word_ready = 1'b1;
    got_q.delete();
    start_capture(7'd1, 9'd10);
    for (int i = 0; i < 20; i++) begin
      q = 1'b0;
      step();
    end
    for (int i = 0; i < 32; i++) begin
      q = ((i % 2) == 0);
      step();
    end
    q = 1'b0;
    wait_idle(40, "trigger_drain");
    step();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL trigger_count: got %0d words want 1", got_q.size());
    end else if (got_q[0] !== exp) begin
      errors++;
      $display("FAIL trigger_word: got %h want %h", got_q[0], exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arm_timeout();
    test_ignore_opcode();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_count_zero();
    test_reset_mid_capture();
    test_trigger();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
